// File: rtl/memory_unit.sv
// Memory stage of the RV32IM pipeline: byte-masked stores, load alignment, Zicntr CSR reads, MW register.
// Optional counters are built when MEMORY_UNIT_ZICNTR_EN is defined; otherwise every CSR read returns 0.
module memory_unit (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        M_stall_i,
    input  logic        W_flush_i,
    input  logic [31:0] EM_PC_i,
    input  logic [31:0] EM_instr_i,
    input  logic        EM_nop_i,
    input  logic        EM_isLoad_i,
    input  logic        EM_isStore_i,
    input  logic        EM_isCSR_i,
    input  logic        EM_wbEnable_i,
    input  logic [4:0]  EM_rdId_i,
    input  logic [4:0]  EM_rs2Id_i,
    input  logic [11:0] EM_csrId_i,
    input  logic [2:0]  EM_funct3_i,
    input  logic [31:0] EM_rs2_i,
    input  logic [31:0] EM_Eresult_i,
    input  logic [31:0] EM_addr_i,
    input  logic [31:0] EM_Mdata_i,
    output logic [31:0] DMemWAddr_o,
    output logic [31:0] DMemWData_o,
    output logic [3:0]  DMemWMask_o,
    output logic [31:0] MW_PC_o,
    output logic [31:0] MW_instr_o,
    output logic        MW_nop_o,
    output logic        MW_wbEnable_o,
    output logic [4:0]  MW_rdId_o,
    output logic [31:0] MW_wbData_o
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

    logic [1:0]  lane;
    logic [31:0] store_src;
    logic [3:0]  lane_mask;
    logic        store_en;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] csr_data;
    logic [31:0] wb_data;

    assign lane = EM_addr_i[1:0];

    // Forward from MW so a store right behind a load to its source register sees the loaded value.
    assign store_src = (MW_wbEnable_o && (MW_rdId_o == EM_rs2Id_i)) ? MW_wbData_o : EM_rs2_i;

    always_comb begin
        DMemWData_o = store_src;
        lane_mask   = 4'b0000;
        case (EM_funct3_i)
            3'b000: begin
                DMemWData_o = {4{store_src[7:0]}};
                lane_mask   = 4'b0001 << lane;
            end
            3'b001: begin
                DMemWData_o = {2{store_src[15:0]}};
                lane_mask   = lane[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                DMemWData_o = store_src;
                lane_mask   = 4'b1111;
            end
            default: begin
                DMemWData_o = store_src;
                lane_mask   = 4'b0000;
            end
        endcase
    end

    assign store_en    = EM_isStore_i && !EM_nop_i && !M_stall_i && !reset_i;
    assign DMemWMask_o = store_en ? lane_mask : 4'b0000;
    assign DMemWAddr_o = {EM_addr_i[31:2], 2'b00};

    always_comb begin
        case (lane)
            2'd0:    load_byte = EM_Mdata_i[7:0];
            2'd1:    load_byte = EM_Mdata_i[15:8];
            2'd2:    load_byte = EM_Mdata_i[23:16];
            default: load_byte = EM_Mdata_i[31:24];
        endcase
        load_half = lane[1] ? EM_Mdata_i[31:16] : EM_Mdata_i[15:0];
        case (EM_funct3_i[1:0])
            2'b00:   load_data = EM_funct3_i[2] ? {24'h0, load_byte}
                                                : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_data = EM_funct3_i[2] ? {16'h0, load_half}
                                                : {{16{load_half[15]}}, load_half};
            default: load_data = EM_Mdata_i;
        endcase
    end

`ifdef MEMORY_UNIT_ZICNTR_EN
    logic [63:0] cycle_q;
    logic [63:0] instret_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (!EM_nop_i && !M_stall_i && !W_flush_i) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    always_comb begin
        case (EM_csrId_i)
            12'hC00, 12'hC01: csr_data = cycle_q[31:0];
            12'hC80, 12'hC81: csr_data = cycle_q[63:32];
            12'hC02:          csr_data = instret_q[31:0];
            12'hC82:          csr_data = instret_q[63:32];
            default:          csr_data = '0;
        endcase
    end
`else
    logic csr_id_unused;
    assign csr_id_unused = ^EM_csrId_i;
    assign csr_data      = '0;
`endif

    assign wb_data = EM_isLoad_i ? load_data : (EM_isCSR_i ? csr_data : EM_Eresult_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            MW_PC_o       <= '0;
            MW_instr_o    <= NOP_INSTR;
            MW_nop_o      <= 1'b1;
            MW_wbEnable_o <= 1'b0;
            MW_rdId_o     <= '0;
            MW_wbData_o   <= '0;
        end else if (W_flush_i) begin
            MW_PC_o       <= EM_PC_i;
            MW_instr_o    <= NOP_INSTR;
            MW_nop_o      <= 1'b1;
            MW_wbEnable_o <= 1'b0;
            MW_rdId_o     <= EM_rdId_i;
            MW_wbData_o   <= wb_data;
        end else if (!M_stall_i) begin
            MW_PC_o       <= EM_PC_i;
            MW_instr_o    <= EM_instr_i;
            MW_nop_o      <= EM_nop_i;
            MW_wbEnable_o <= EM_wbEnable_i;
            MW_rdId_o     <= EM_rdId_i;
            MW_wbData_o   <= wb_data;
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// Directed self-checking bench for memory_unit; counter expectations follow MEMORY_UNIT_ZICNTR_EN.
module tb_memory_unit;

`ifdef MEMORY_UNIT_ZICNTR_EN
    localparam bit ZICNTR = 1'b1;
`else
    localparam bit ZICNTR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i, M_stall_i, W_flush_i;
    logic [31:0] EM_PC_i, EM_instr_i;
    logic        EM_nop_i, EM_isLoad_i, EM_isStore_i, EM_isCSR_i, EM_wbEnable_i;
    logic [4:0]  EM_rdId_i, EM_rs2Id_i;
    logic [11:0] EM_csrId_i;
    logic [2:0]  EM_funct3_i;
    logic [31:0] EM_rs2_i, EM_Eresult_i, EM_addr_i, EM_Mdata_i;
    logic [31:0] DMemWAddr_o, DMemWData_o;
    logic [3:0]  DMemWMask_o;
    logic [31:0] MW_PC_o, MW_instr_o;
    logic        MW_nop_o, MW_wbEnable_o;
    logic [4:0]  MW_rdId_o;
    logic [31:0] MW_wbData_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] cyc_m = '0;
    logic [63:0] ret_m = '0;

    memory_unit dut (
        .clk_i(clk), .reset_i(reset_i), .M_stall_i(M_stall_i), .W_flush_i(W_flush_i),
        .EM_PC_i(EM_PC_i), .EM_instr_i(EM_instr_i), .EM_nop_i(EM_nop_i),
        .EM_isLoad_i(EM_isLoad_i), .EM_isStore_i(EM_isStore_i), .EM_isCSR_i(EM_isCSR_i),
        .EM_wbEnable_i(EM_wbEnable_i), .EM_rdId_i(EM_rdId_i), .EM_rs2Id_i(EM_rs2Id_i),
        .EM_csrId_i(EM_csrId_i), .EM_funct3_i(EM_funct3_i), .EM_rs2_i(EM_rs2_i),
        .EM_Eresult_i(EM_Eresult_i), .EM_addr_i(EM_addr_i), .EM_Mdata_i(EM_Mdata_i),
        .DMemWAddr_o(DMemWAddr_o), .DMemWData_o(DMemWData_o), .DMemWMask_o(DMemWMask_o),
        .MW_PC_o(MW_PC_o), .MW_instr_o(MW_instr_o), .MW_nop_o(MW_nop_o),
        .MW_wbEnable_o(MW_wbEnable_o), .MW_rdId_o(MW_rdId_o), .MW_wbData_o(MW_wbData_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Independent counter model, advanced from the inputs presented at each edge.
    task automatic step();
        @(posedge clk);
        if (reset_i) begin
            cyc_m = '0;
            ret_m = '0;
        end else begin
            if (!EM_nop_i && !M_stall_i && !W_flush_i) ret_m = ret_m + 64'd1;
            cyc_m = cyc_m + 64'd1;
        end
        #1;
    endtask

    function automatic logic [31:0] exp_csr(input logic [11:0] id);
        logic [31:0] v;
        case (id)
            12'hC00, 12'hC01: v = cyc_m[31:0];
            12'hC80, 12'hC81: v = cyc_m[63:32];
            12'hC02:          v = ret_m[31:0];
            12'hC82:          v = ret_m[63:32];
            default:          v = 32'h0;
        endcase
        return ZICNTR ? v : 32'h0;
    endfunction

    task automatic idle();
        M_stall_i = 0; W_flush_i = 0;
        EM_PC_i = 32'h0; EM_instr_i = 32'h0000_0033; EM_nop_i = 1;
        EM_isLoad_i = 0; EM_isStore_i = 0; EM_isCSR_i = 0; EM_wbEnable_i = 0;
        EM_rdId_i = 0; EM_rs2Id_i = 0; EM_csrId_i = 0; EM_funct3_i = 0;
        EM_rs2_i = 0; EM_Eresult_i = 0; EM_addr_i = 0; EM_Mdata_i = 0;
    endtask

    task automatic op(input logic [31:0] pc, input logic [4:0] rd, input logic wb);
        idle();
        EM_PC_i = pc; EM_instr_i = pc ^ 32'h0000_1013; EM_nop_i = 0;
        EM_rdId_i = rd; EM_wbEnable_i = wb;
    endtask

    task automatic csr_read(input string tag, input logic [11:0] id, input logic [31:0] pc);
        logic [31:0] e;
        op(pc, 5'd1, 1'b1);
        EM_isCSR_i = 1; EM_csrId_i = id;
        e = exp_csr(id);
        step();
        check(tag, MW_wbData_o, e);
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] md, input logic [31:0] exp);
        op(32'h100, 5'd5, 1'b1);
        EM_isLoad_i = 1; EM_funct3_i = f3; EM_addr_i = addr; EM_Mdata_i = md;
        step();
        check(tag, MW_wbData_o, exp);
    endtask

    task automatic store_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] d, input logic [31:0] ed, input logic [3:0] em);
        op(32'h180, 5'd0, 1'b0);
        EM_isStore_i = 1; EM_funct3_i = f3; EM_addr_i = addr; EM_rs2_i = d; EM_rs2Id_i = 5'd7;
        #1;
        check({tag, "_addr"}, DMemWAddr_o, {addr[31:2], 2'b00});
        check({tag, "_data"}, DMemWData_o, ed);
        check({tag, "_mask"}, {28'h0, DMemWMask_o}, {28'h0, em});
        step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, MW_PC_o, 32'h0);
        check({tag, "_rd"}, {27'h0, MW_rdId_o}, 32'h0);
        check({tag, "_wb"}, MW_wbData_o, 32'h0);
        check({tag, "_instr"}, MW_instr_o, 32'h0000_0033);
        check({tag, "_nop"}, {31'h0, MW_nop_o}, 32'h1);
        check({tag, "_wben"}, {31'h0, MW_wbEnable_o}, 32'h0);
    endtask

    initial begin
        idle();
        reset_i = 1;
        // Store presented during reset must not write.
        EM_nop_i = 0; EM_isStore_i = 1; EM_funct3_i = 3'b010;
        #1;
        check("rst_store_mask", {28'h0, DMemWMask_o}, 32'h0);
        step();
        step();
        check_reset_state("rst");

        idle();
        reset_i = 0;
        repeat (10) step();
        op(32'h40, 5'd1, 1'b1);
        EM_isCSR_i = 1; EM_csrId_i = 12'hC00;
        step();
        check("csr_cycle10", MW_wbData_o, ZICNTR ? 32'd10 : 32'd0);
        csr_read("csr_c82", 12'hC82, 32'h44);
        csr_read("csr_c01", 12'hC01, 32'h48);
        csr_read("csr_instret", 12'hC02, 32'h4C);
        csr_read("csr_c80", 12'hC80, 32'h50);
        csr_read("csr_other", 12'h123, 32'h54);
        check("mw_pc", MW_PC_o, 32'h54);
        check("mw_instr", MW_instr_o, 32'h54 ^ 32'h0000_1013);

        store_chk("sb3", 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'hDDDD_DDDD, 4'b1000);
        store_chk("sb1", 3'b000, 32'h0000_1001, 32'hAABB_CCDD, 32'hDDDD_DDDD, 4'b0010);
        store_chk("sh2", 3'b001, 32'h0000_1002, 32'h1122_3344, 32'h3344_3344, 4'b1100);
        store_chk("sh1", 3'b001, 32'h0000_1001, 32'h1122_3344, 32'h3344_3344, 4'b0011);
        store_chk("sw3", 3'b010, 32'h0000_1007, 32'h1122_3344, 32'h1122_3344, 4'b1111);
        store_chk("sbad", 3'b011, 32'h0000_1000, 32'h1122_3344, 32'h1122_3344, 4'b0000);

        load("lb",  3'b000, 32'h0000_2001, 32'h1234_80FF, 32'hFFFF_FF80);
        load("lbu", 3'b100, 32'h0000_2001, 32'h1234_80FF, 32'h0000_0080);
        load("lb3", 3'b000, 32'h0000_2003, 32'h1234_80FF, 32'h0000_0012);
        load("lh",  3'b001, 32'h0000_2003, 32'h8001_1234, 32'hFFFF_8001);
        load("lhu", 3'b101, 32'h0000_2002, 32'h8001_1234, 32'h0000_8001);
        load("lh0", 3'b001, 32'h0000_2001, 32'h8001_F234, 32'hFFFF_F234);
        load("lw",  3'b010, 32'h0000_2001, 32'hCAFE_F00D, 32'hCAFE_F00D);
        check("lw_rd", {27'h0, MW_rdId_o}, 32'd5);

        // Previous op is LW x5: a SW of x5 must take the loaded word.
        op(32'h200, 5'd0, 1'b0);
        EM_isStore_i = 1; EM_funct3_i = 3'b010; EM_rs2Id_i = 5'd5; EM_rs2_i = 32'hDEAD_0000;
        EM_addr_i = 32'h0000_3000;
        #1;
        check("fwd_data", DMemWData_o, 32'hCAFE_F00D);
        step();

        op(32'h204, 5'd0, 1'b0);
        EM_isStore_i = 1; EM_funct3_i = 3'b001; EM_rs2Id_i = 5'd6; EM_rs2_i = 32'h0000_BEEF;
        EM_addr_i = 32'h0000_3000; M_stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_mask", {28'h0, DMemWMask_o}, 32'h0);
            step();
            check("stall_hold_pc", MW_PC_o, 32'h200);
        end
        M_stall_i = 0;
        #1;
        check("rel_mask", {28'h0, DMemWMask_o}, 32'h3);
        check("rel_data", DMemWData_o, 32'hBEEF_BEEF);
        step();
        check("rel_pc", MW_PC_o, 32'h204);
        csr_read("csr_instret2", 12'hC02, 32'h208);

        op(32'h300, 5'd9, 1'b1);
        EM_Eresult_i = 32'h77; M_stall_i = 1; W_flush_i = 1;
        step();
        check("flush_nop", {31'h0, MW_nop_o}, 32'h1);
        check("flush_wben", {31'h0, MW_wbEnable_o}, 32'h0);
        check("flush_instr", MW_instr_o, 32'h0000_0033);
        M_stall_i = 0; W_flush_i = 0;
        step();
        check("alu_wb", MW_wbData_o, 32'h77);
        check("alu_nop", {31'h0, MW_nop_o}, 32'h0);
        csr_read("csr_instret3", 12'hC02, 32'h304);

        op(32'h400, 5'd3, 1'b1);
        EM_isStore_i = 1; EM_funct3_i = 3'b010; EM_addr_i = 32'h0000_5000; reset_i = 1;
        #1;
        check("midrst_mask", {28'h0, DMemWMask_o}, 32'h0);
        step();
        check_reset_state("midrst");
        reset_i = 0;
        csr_read("post_rst_cycle", 12'hC00, 32'h10);
        check("post_rst_cycle0", MW_wbData_o, 32'h0);
        csr_read("post_rst_instret", 12'hC02, 32'h14);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_unit.md
# memory_unit

Memory stage of the five-stage RV32IM pipeline. Consumes the EM pipeline register produced by the execute stage, issues byte-masked stores to data memory, and aligns and sign-extends load data already fetched during execute. It also services read-only Zicntr counter CSRs and drives the MW pipeline register that feeds writeback and the execute stage's forwarding path.

## Interface
Parameters:
- none

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  pipeline clock
- reset_i  in  1  synchronous active-high reset
- M_stall_i  in  1  hold MW registers; suppress store write
- W_flush_i  in  1  load a bubble into MW
- EM_PC_i, EM_instr_i  in  32  PC / instruction of the M-stage op
- EM_nop_i, EM_isLoad_i, EM_isStore_i, EM_isCSR_i, EM_wbEnable_i  in  1  op class; wbEnable already excludes rd=x0
- EM_rdId_i, EM_rs2Id_i  in  5  destination and store-source register ids
- EM_csrId_i  in  12  CSR address
- EM_funct3_i  in  3  load/store width and sign
- EM_rs2_i, EM_Eresult_i, EM_addr_i, EM_Mdata_i  in  32  store data, execute result, byte address, word read at EM_addr_i[31:2]
- DMemWAddr_o  out  32  {EM_addr_i[31:2], 2'b00}
- DMemWData_o  out  32  lane-replicated store data
- DMemWMask_o  out  4  byte write enables; 0 means no write
- MW_PC_o, MW_instr_o  out  32  registered PC / instruction
- MW_nop_o  out  1  registered bubble flag
- MW_wbEnable_o  out  1  registered write-enable
- MW_rdId_o  out  5  registered destination id
- MW_wbData_o  out  32  registered writeback value

## Operation
- Store-data forwarding: if MW_wbEnable_o && MW_rdId_o == EM_rs2Id_i, store data = MW_wbData_o, otherwise EM_rs2_i. This covers load→store back-to-back.
- Store lanes, with a = EM_addr_i[1:0]:
  - SB (000): data {4{d[7:0]}}, mask 4'b0001 << a
  - SH (001): data {2{d[15:0]}}, mask a[1] ? 4'b1100 : 4'b0011
  - SW (010): data d, mask 4'b1111
  - Other funct3 values: mask 0.
- Mask is gated by EM_isStore_i && !EM_nop_i && !M_stall_i && !reset_i.
- Misaligned accesses do not trap. Half-word accesses use a[1] and ignore a[0]. Word accesses ignore a.
- Load format from EM_Mdata_i:
  - LB / LBU: byte at lane a
  - LH / LHU: half at a[1]
  - LW: full word
  - funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
- CSR read, counters read-only (writes ignored):
  - 0xC00 / 0xC01: cycle[31:0]
  - 0xC80 / 0xC81: cycle[63:32]
  - 0xC02: instret[31:0]
  - 0xC82: instret[63:32]
  - any other address: 0
- Writeback select: isLoad ? loadData : isCSR ? csrData : EM_Eresult_i.
- Counters, 64-bit, wrap to 0 after 2^64−1:
  - cycle increments every non-reset cycle.
  - instret increments on each edge where MW accepts an op with !EM_nop_i, !M_stall_i, !W_flush_i.
  - A CSR read returns the counter value before that edge's increment.

## Timing
- Store interface is combinational from EM inputs and is written on the edge ending the M cycle. Zero added latency.
- MW registers load on each edge with !M_stall_i. Latency 1 cycle.
- Priority order: reset_i > W_flush_i > M_stall_i.
- Flush state: MW_instr_o = 32'h00000033, MW_nop_o = 1, MW_wbEnable_o = 0. Other MW fields are don't-care.
- Flush and stall together: the flush wins.
- Stall: MW holds its value, no store is written, instret does not increment, cycle still increments.
- Reset state, including mid-operation: cycle = 0, instret = 0, MW_PC_o = 0, MW_rdId_o = 0, MW_wbData_o = 0, MW_instr_o = 32'h00000033, MW_nop_o = 1, MW_wbEnable_o = 0.
- A store presented in the reset cycle is dropped.

## Configuration
- Macro: MEMORY_UNIT_ZICNTR_EN.
- Defined: cycle/instret counters are built and readable as above.
- Undefined: no counter registers exist and every CSR read returns 0. Load, store and writeback behaviour is unchanged.

## Test plan
- SB, addr 0x1003, rs2 0xAABBCCDD → DMemWAddr_o 0x1000, DMemWData_o 0xDDDDDDDD, DMemWMask_o 4'b1000.
- LB, addr 0x2001, Mdata 0x1234_80FF → MW_wbData_o 0xFFFFFF80. Same with LBU → 0x00000080.
- LW x5 followed by SW of x5: the SW's store data equals the loaded word, not the stale EM_rs2_i.
- Release reset, wait 10 cycles, read CSR 0xC00 (with MEMORY_UNIT_ZICNTR_EN) → wbData 10. Read 0xC82 → 0. Without the macro both read 0.
- SH with M_stall_i=1 for 3 cycles → mask 0 while stalled, one write when released, MW held, instret +1 total. Assert W_flush_i together with the stall → MW_nop_o 1 and MW_wbEnable_o 0 next cycle.
- Assert reset_i mid-stream with a store pending → mask 0, and all MW outputs and counters take their reset values on the next edge.
